// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Constants shared by the control-module blocks (ck16 domain).
// Holds the boot data streamer state encoding and the byte-lane selection
// helpers used when packing SD-card bytes into 32-bit boot words.
// No ports: package only.
// ---------------------------------------------------------------------------
package ctrl_pkg;

   // Boot data streamer FSM states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_OFFER,
      ST_WAIT_REQ_LOW,
      ST_DONE
   } bds_state_e;

   // Byte index of the last byte of a word, and the highest byte lane
   localparam logic [1:0] BDS_IDX_LAST = 2'd3;
   localparam logic [1:0] BDS_LANE_TOP = 2'd3;

   // Maps the running byte index onto a byte lane of the 32-bit word.
   // With first_msb set, byte 0 lands in [31:24]; otherwise in [7:0].
   function automatic logic [1:0] bds_lane(input logic [1:0] idx, input logic first_msb);
      return first_msb ? (BDS_LANE_TOP - idx) : idx;
   endfunction

endpackage

// File: rtl/boot_data_streamer_if.sv
// ---------------------------------------------------------------------------
// boot_data_streamer_if
// Bundles the control, SD byte-stream and host boot-word signals of the
// boot data streamer.
//   slave  : the streamer side (receives start/abort/bytes/req, drives
//            byte_ready, host_bootdata, ack, rom_initialised, busy)
//   master : the environment side (the mirror image)
// ---------------------------------------------------------------------------
interface boot_data_streamer_if #(
   parameter int LEN_W = 17
);
   logic             start;
   logic             abort;
   logic [LEN_W-1:0] word_count;
   logic [7:0]       byte_data;
   logic             byte_valid;
   logic             byte_ready;
   logic [31:0]      host_bootdata;
   logic             host_bootdata_req;
   logic             host_bootdata_ack;
   logic             host_rom_initialised;
   logic             busy;

   modport slave (
      input  start, abort, word_count, byte_data, byte_valid, host_bootdata_req,
      output byte_ready, host_bootdata, host_bootdata_ack, host_rom_initialised, busy
   );

   modport master (
      output start, abort, word_count, byte_data, byte_valid, host_bootdata_req,
      input  byte_ready, host_bootdata, host_bootdata_ack, host_rom_initialised, busy
   );
endinterface

// File: rtl/boot_data_streamer_byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
// Assembles accepted bytes into a 32-bit word. A 2-bit index selects the
// byte lane; on the fourth byte the completed word is copied to word_out,
// which then holds until the next word completes.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   clear       : restart the index at byte 0 (partial word discarded)
//   accept      : a byte is transferred this cycle
//   byte_data   : the byte being transferred
//   word_done   : this accepted byte completes a word
//   word_out    : last completed word
// ---------------------------------------------------------------------------
module byte_packer
   import ctrl_pkg::*;
#(
   parameter bit FIRST_MSB = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        accept,
   input  logic [7:0]  byte_data,
   output logic        word_done,
   output logic [31:0] word_out
);

   logic [1:0]  idx_q, idx_d;
   logic [31:0] buf_q, buf_d;
   logic [31:0] word_q, word_d;
   logic [1:0]  lane;

   // Lane write and index advance. The completed word is taken from buf_d
   // so the fourth byte is included in the same cycle it arrives.
   always_comb begin
      lane      = bds_lane(idx_q, FIRST_MSB);
      idx_d     = idx_q;
      buf_d     = buf_q;
      word_d    = word_q;
      word_done = 1'b0;
      if (clear) begin
         idx_d = '0;
      end else if (accept) begin
         buf_d[{lane, 3'b000} +: 8] = byte_data;
         idx_d = idx_q + 2'd1;
         if (idx_q == BDS_IDX_LAST) begin
            word_done = 1'b1;
            word_d    = buf_d;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q  <= '0;
         buf_q  <= '0;
         word_q <= '0;
      end else begin
         idx_q  <= idx_d;
         buf_q  <= buf_d;
         word_q <= word_d;
      end
   end

   assign word_out = word_q;

endmodule

// File: rtl/boot_data_streamer.sv
// ---------------------------------------------------------------------------
// boot_data_streamer
// Streams word_count 32-bit boot words, packed from SD sector bytes, to the
// core ROM loader using a req/ack handshake. Each ack needs a fresh rising
// req, and host_rom_initialised rises once all words have been delivered.
// Ports:
//   clk, reset : ck16 clock, asynchronous active-high reset
//   bus        : boot_data_streamer_if.slave (control, byte stream, host)
// ---------------------------------------------------------------------------
module boot_data_streamer
   import ctrl_pkg::*;
#(
   parameter int LEN_W     = 17,
   parameter bit FIRST_MSB = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   boot_data_streamer_if.slave bus
);

   bds_state_e       state_q, state_d;
   logic [LEN_W-1:0] remaining_q, remaining_d;
   logic             fill_ready;
   logic             accept;
   logic             ack;
   logic             pack_clear;
   logic             word_done;
   logic [31:0]      word_out;

   // Handshake outputs are decoded from the state; abort suppresses them at
   // once so no byte or word is transferred in the cycle being cancelled.
   assign fill_ready = (state_q == ST_FILL) && !bus.abort;
   assign accept     = fill_ready && bus.byte_valid;
   assign ack        = (state_q == ST_OFFER) && bus.host_bootdata_req && !bus.abort;

   assign bus.byte_ready           = fill_ready;
   assign bus.host_bootdata_ack    = ack;
   assign bus.host_bootdata        = word_out;
   assign bus.host_rom_initialised = (state_q == ST_DONE) && !bus.start && !bus.abort;
   assign bus.busy                 = (state_q == ST_FILL) || (state_q == ST_OFFER) ||
                                     (state_q == ST_WAIT_REQ_LOW);

   byte_packer #(
      .FIRST_MSB (FIRST_MSB)
   ) u_packer (
      .clk       (clk),
      .reset     (reset),
      .clear     (pack_clear),
      .accept    (accept),
      .byte_data (bus.byte_data),
      .word_done (word_done),
      .word_out  (word_out)
   );

   // Next-state logic. remaining only decrements in OFFER where it is at
   // least 1, so it can never wrap; reaching 0 on an ack ends the transfer.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      pack_clear  = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               pack_clear = 1'b1;
               if (bus.word_count == '0) begin
                  state_d = ST_DONE;
               end else begin
                  remaining_d = bus.word_count;
                  state_d     = ST_FILL;
               end
            end
         end
         ST_FILL: begin
            if (word_done) state_d = ST_OFFER;
         end
         ST_OFFER: begin
            if (ack) begin
               remaining_d = remaining_q - LEN_W'(1);
               state_d     = (remaining_q == LEN_W'(1)) ? ST_DONE : ST_WAIT_REQ_LOW;
            end
         end
         ST_WAIT_REQ_LOW: begin
            if (!bus.host_bootdata_req) state_d = ST_FILL;
         end
         default: state_d = ST_IDLE;
      endcase
      if (bus.abort) begin
         state_d    = ST_IDLE;
         pack_clear = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
      end
   end

endmodule

// File: tb/tb_boot_data_streamer.sv
// ---------------------------------------------------------------------------
// tb_boot_data_streamer
// Scoreboard bench for boot_data_streamer. Stimulus pushes expected boot
// words into per-instance queues; forked monitors pop and compare on every
// ack. dut0 packs MSB-first, dut1 packs LSB-first.
// ---------------------------------------------------------------------------
module tb_boot_data_streamer;

   localparam int LEN_W = 17;

   logic clk = 1'b0;
   logic reset;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [31:0] exp0[$];
   logic [31:0] exp1[$];

   always #5 clk = ~clk;

   boot_data_streamer_if #(.LEN_W(LEN_W)) bus0 ();
   boot_data_streamer_if #(.LEN_W(LEN_W)) bus1 ();

   boot_data_streamer #(.LEN_W(LEN_W), .FIRST_MSB(1'b1)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   boot_data_streamer #(.LEN_W(LEN_W), .FIRST_MSB(1'b0)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
      end
   endtask

   task automatic checkFlag(input string name, input logic actual, input logic expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %b, required %b", name, actual, expected);
      end
   endtask

   // Pops the expected word on every ack seen by the given instance
   task automatic monitorAck(input int sel);
      logic        a;
      logic [31:0] d;
      logic [31:0] e;
      forever begin
         @(negedge clk);
         a = (sel == 0) ? bus0.host_bootdata_ack : bus1.host_bootdata_ack;
         d = (sel == 0) ? bus0.host_bootdata : bus1.host_bootdata;
         if (a === 1'b1) begin
            tests_run++;
            if ((sel == 0 && exp0.size() == 0) || (sel == 1 && exp1.size() == 0)) begin
               tests_failed++;
               $display("[TB] FAIL ack%0d_unexpected: got ack with data %h, required no ack",
                        sel, d);
            end else begin
               e = (sel == 0) ? exp0.pop_front() : exp1.pop_front();
               if (d !== e) begin
                  tests_failed++;
                  $display("[TB] FAIL ack%0d_data: got %h, required %h", sel, d, e);
               end
            end
         end
      end
   endtask

   // One-cycle start and/or abort pulse
   task automatic applyStimulus(input int sel, input logic do_start, input logic do_abort,
                                input logic [LEN_W-1:0] wc);
      if (sel == 0) begin
         bus0.start = do_start; bus0.abort = do_abort; bus0.word_count = wc;
      end else begin
         bus1.start = do_start; bus1.abort = do_abort; bus1.word_count = wc;
      end
      tick(1);
      bus0.start = 1'b0; bus0.abort = 1'b0;
      bus1.start = 1'b0; bus1.abort = 1'b0;
   endtask

   task automatic sendByte(input int sel, input logic [7:0] b);
      bit done = 1'b0;
      logic r;
      if (sel == 0) begin bus0.byte_data = b; bus0.byte_valid = 1'b1; end
      else          begin bus1.byte_data = b; bus1.byte_valid = 1'b1; end
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         r = (sel == 0) ? bus0.byte_ready : bus1.byte_ready;
         if (r === 1'b1) begin
            @(posedge clk);
            #1;
            done = 1'b1;
         end
      end
      bus0.byte_valid = 1'b0;
      bus1.byte_valid = 1'b0;
      if (!done) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL byte_timeout: got no byte_ready for %h, required byte_ready=1", b);
      end
   endtask

   task automatic sendWord(input int sel, input logic [31:0] w);
      for (int i = 3; i >= 0; i--) sendByte(sel, w[i*8 +: 8]);
   endtask

   task automatic waitAck(input int sel);
      bit done = 1'b0;
      logic a;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         a = (sel == 0) ? bus0.host_bootdata_ack : bus1.host_bootdata_ack;
         if (a === 1'b1) done = 1'b1;
      end
      if (done) begin
         @(posedge clk);
         #1;
      end else begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL ack_timeout: got ack=0 on dut%0d, required ack=1", sel);
      end
   endtask

   // Host drops req for one cycle so the next word can be offered
   task automatic reqBlip();
      bus0.host_bootdata_req = 1'b0;
      tick(1);
      bus0.host_bootdata_req = 1'b1;
   endtask

   initial begin
      reset = 1'b1;
      bus0.start = 1'b0; bus0.abort = 1'b0; bus0.word_count = '0;
      bus0.byte_data = '0; bus0.byte_valid = 1'b0; bus0.host_bootdata_req = 1'b0;
      bus1.start = 1'b0; bus1.abort = 1'b0; bus1.word_count = '0;
      bus1.byte_data = '0; bus1.byte_valid = 1'b0; bus1.host_bootdata_req = 1'b0;
      fork
         monitorAck(0);
         monitorAck(1);
      join_none

      // Reset state
      tick(2);
      checkFlag("rst_busy", bus0.busy, 1'b0);
      checkFlag("rst_ack", bus0.host_bootdata_ack, 1'b0);
      checkFlag("rst_byte_ready", bus0.byte_ready, 1'b0);
      checkFlag("rst_init", bus0.host_rom_initialised, 1'b0);
      checkOutput("rst_bootdata", bus0.host_bootdata, 32'h0);
      reset = 1'b0;
      tick(1);

      // Two words, MSB-first
      $display("[TB] two words MSB-first");
      bus0.host_bootdata_req = 1'b1;
      exp0.push_back(32'h11223344);
      exp0.push_back(32'h55667788);
      applyStimulus(0, 1'b1, 1'b0, 17'd2);
      checkFlag("busy_fill", bus0.busy, 1'b1);
      sendWord(0, 32'h11223344);
      waitAck(0);
      reqBlip();
      sendWord(0, 32'h55667788);
      waitAck(0);
      tick(3);
      checkFlag("two_init", bus0.host_rom_initialised, 1'b1);
      checkFlag("two_busy", bus0.busy, 1'b0);
      checkOutput("two_queue_left", 32'(exp0.size()), 32'd0);

      // One word, LSB-first
      $display("[TB] one word LSB-first");
      bus1.host_bootdata_req = 1'b1;
      exp1.push_back(32'h44332211);
      applyStimulus(1, 1'b1, 1'b0, 17'd1);
      sendWord(1, 32'h11223344);
      waitAck(1);
      checkFlag("lsb_init", bus1.host_rom_initialised, 1'b1);

      // Req held high: one ack per rising req, no fourth ack
      $display("[TB] req held high, three words");
      exp0.push_back(32'hA1A2A3A4);
      exp0.push_back(32'hB1B2B3B4);
      exp0.push_back(32'hC1C2C3C4);
      applyStimulus(0, 1'b1, 1'b0, 17'd3);
      sendWord(0, 32'hA1A2A3A4);
      waitAck(0);
      bus0.byte_data = 8'hB1;
      bus0.byte_valid = 1'b1;
      tick(5);
      checkFlag("hold_busy", bus0.busy, 1'b1);
      checkFlag("hold_byte_ready", bus0.byte_ready, 1'b0);
      reqBlip();
      sendWord(0, 32'hB1B2B3B4);
      waitAck(0);
      reqBlip();
      sendWord(0, 32'hC1C2C3C4);
      waitAck(0);
      tick(5);
      checkFlag("three_init", bus0.host_rom_initialised, 1'b1);
      checkOutput("three_queue_left", 32'(exp0.size()), 32'd0);

      // Zero word count
      $display("[TB] zero word count");
      applyStimulus(0, 1'b0, 1'b1, '0);
      checkFlag("abort_init_clr", bus0.host_rom_initialised, 1'b0);
      bus0.byte_valid = 1'b1;
      applyStimulus(0, 1'b1, 1'b0, 17'd0);
      checkFlag("zero_byte_ready_c1", bus0.byte_ready, 1'b0);
      tick(1);
      checkFlag("zero_init_c2", bus0.host_rom_initialised, 1'b1);
      checkFlag("zero_byte_ready_c2", bus0.byte_ready, 1'b0);
      checkFlag("zero_busy", bus0.busy, 1'b0);
      bus0.byte_valid = 1'b0;

      // Abort mid-word, then restart from lane 0
      $display("[TB] abort mid-word");
      exp0.push_back(32'hD1D2D3D4);
      applyStimulus(0, 1'b1, 1'b0, 17'd4);
      sendWord(0, 32'hD1D2D3D4);
      waitAck(0);
      reqBlip();
      sendByte(0, 8'hE1);
      sendByte(0, 8'hE2);
      applyStimulus(0, 1'b0, 1'b1, '0);
      checkFlag("abort_busy", bus0.busy, 1'b0);
      checkFlag("abort_init", bus0.host_rom_initialised, 1'b0);
      checkFlag("abort_byte_ready", bus0.byte_ready, 1'b0);
      checkOutput("abort_bootdata_kept", bus0.host_bootdata, 32'hD1D2D3D4);
      exp0.push_back(32'hF1F2F3F4);
      applyStimulus(0, 1'b1, 1'b0, 17'd1);
      sendWord(0, 32'hF1F2F3F4);
      waitAck(0);
      checkFlag("restart_init", bus0.host_rom_initialised, 1'b1);

      // Reset during OFFER, then start+abort together
      $display("[TB] reset during offer");
      bus0.host_bootdata_req = 1'b0;
      applyStimulus(0, 1'b1, 1'b0, 17'd2);
      sendWord(0, 32'h01020304);
      checkFlag("offer_busy", bus0.busy, 1'b1);
      checkFlag("offer_ack_no_req", bus0.host_bootdata_ack, 1'b0);
      #1 reset = 1'b1;
      #1;
      checkFlag("async_rst_busy", bus0.busy, 1'b0);
      checkOutput("async_rst_bootdata", bus0.host_bootdata, 32'h0);
      bus0.host_bootdata_req = 1'b1;
      #1;
      checkFlag("async_rst_ack", bus0.host_bootdata_ack, 1'b0);
      tick(1);
      reset = 1'b0;
      tick(5);
      checkFlag("post_rst_busy", bus0.busy, 1'b0);
      bus0.start = 1'b1; bus0.abort = 1'b1; bus0.word_count = 17'd1;
      tick(1);
      bus0.start = 1'b0; bus0.abort = 1'b0;
      checkFlag("start_abort_busy", bus0.busy, 1'b0);
      checkFlag("start_abort_byte_ready", bus0.byte_ready, 1'b0);
      tick(3);
      checkFlag("start_abort_still_idle", bus0.busy, 1'b0);
      checkOutput("final_queue0_left", 32'(exp0.size()), 32'd0);
      checkOutput("final_queue1_left", 32'(exp1.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
